regfile_stream_port: RTL and testbench



---
 rtl/regfile_stream_port.sv | 146 ++++++++++++++
 tb/tb_regfile_stream_port.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_stream_port.sv
// Streams words between valid/ready ports and a register file: LOAD writes consecutive
// entries from the input stream, DUMP reads consecutive entries out through a one-word output register.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// LOAD  | one register file write per accepted input beat
// DUMP  | reading entries into the output register, draining on handshakes
// DONE  | one-cycle done pulse, then back to IDLE
module regfile_stream_port #(
    parameter int width = 32,
    parameter int n     = 5,
    parameter int size  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [n-1:0]     cmd_base,
    input  logic [n:0]       cmd_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic             out_last,
    output logic             done,
    output logic [n-1:0]     rf_readReq,
    input  logic [width-1:0] rf_readResp,
    output logic             rf_writeEn,
    output logic [n-1:0]     rf_writeIndex,
    output logic [width-1:0] rf_writeData
);

    typedef enum logic [1:0] {IDLE, LOAD, DUMP, DONE} state_t;

    localparam logic [n-1:0] lastIdx  = n'(size - 1);
    localparam logic [n-1:0] ptrOne   = 1;
    localparam logic [n:0]   countOne = 1;

    state_t         state, stateNext;
    logic [n-1:0]   ptr;
    logic [n:0]     left;
    logic           cmdFire;
    logic           firstLoad;
    logic           dumpLoad;

    function automatic logic [n-1:0] nextPtr(input logic [n-1:0] p);
        return (p == lastIdx) ? '0 : p + ptrOne;
    endfunction

    assign cmdFire   = cmd_valid && cmd_ready;
    // The first DUMP word is captured on the accept edge so out_valid rises one cycle after accept.
    assign firstLoad = cmdFire && cmd_op && (cmd_count != '0);
    assign dumpLoad  = (state == DUMP) && (left != '0) && (!out_valid || out_ready);

    always_comb begin
        stateNext     = state;
        cmd_ready     = 1'b0;
        in_ready      = 1'b0;
        done          = 1'b0;
        rf_writeEn    = 1'b0;
        rf_writeIndex = ptr;
        rf_writeData  = in_data;
        rf_readReq    = ptr;
        case (state)
            IDLE: begin
                cmd_ready  = !rst;
                rf_readReq = cmd_base;
                if (cmd_valid && !rst) begin
                    if (cmd_count == '0)
                        stateNext = DONE;
                    else if (cmd_op)
                        stateNext = DUMP;
                    else
                        stateNext = LOAD;
                end
            end
            LOAD: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    rf_writeEn = 1'b1;
                    if (left == countOne)
                        stateNext = DONE;
                end
            end
            DUMP: begin
                if (out_valid && out_ready && out_last)
                    stateNext = DONE;
            end
            DONE: begin
                done      = !rst;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            left      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (firstLoad) begin
                        out_data  <= rf_readResp;
                        out_valid <= 1'b1;
                        out_last  <= (cmd_count == countOne);
                        ptr       <= nextPtr(cmd_base);
                        left      <= cmd_count - countOne;
                    end else if (cmdFire) begin
                        ptr  <= cmd_base;
                        left <= cmd_count;
                    end
                end
                LOAD: begin
                    if (rf_writeEn) begin
                        ptr  <= nextPtr(ptr);
                        left <= left - countOne;
                    end
                end
                DUMP: begin
                    if (dumpLoad) begin
                        out_data  <= rf_readResp;
                        out_valid <= 1'b1;
                        out_last  <= (left == countOne);
                        ptr       <= nextPtr(ptr);
                        left      <= left - countOne;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_stream_port.sv
// Directed bench for regfile_stream_port: two instances (size 32 and size 20), each
// attached to a small behavioural register file model.
module tb_regfile_stream_port;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // instance A, size 32
    logic        cmdValidA = 0, cmdReadyA, cmdOpA = 0;
    logic [4:0]  cmdBaseA = 0;
    logic [5:0]  cmdCountA = 0;
    logic        inValidA = 0, inReadyA;
    logic [31:0] inDataA = 0;
    logic        outValidA, outReadyA = 0, outLastA, doneA;
    logic [31:0] outDataA;
    logic [4:0]  rdReqA, wrIdxA;
    logic [31:0] rdRespA, wrDataA;
    logic        wrEnA;
    logic [31:0] memA [32];

    // instance B, size 20
    logic        cmdValidB = 0, cmdReadyB, cmdOpB = 0;
    logic [4:0]  cmdBaseB = 0;
    logic [5:0]  cmdCountB = 0;
    logic        inValidB = 0, inReadyB;
    logic [31:0] inDataB = 0;
    logic        outValidB, outReadyB = 0, outLastB, doneB;
    logic [31:0] outDataB;
    logic [4:0]  rdReqB, wrIdxB;
    logic [31:0] rdRespB, wrDataB;
    logic        wrEnB;
    logic [31:0] memB [32];

    regfile_stream_port #(.width(32), .n(5), .size(32)) dutA (
        .clk(clk), .rst(rst),
        .cmd_valid(cmdValidA), .cmd_ready(cmdReadyA), .cmd_op(cmdOpA),
        .cmd_base(cmdBaseA), .cmd_count(cmdCountA),
        .in_valid(inValidA), .in_ready(inReadyA), .in_data(inDataA),
        .out_valid(outValidA), .out_ready(outReadyA), .out_data(outDataA),
        .out_last(outLastA), .done(doneA),
        .rf_readReq(rdReqA), .rf_readResp(rdRespA),
        .rf_writeEn(wrEnA), .rf_writeIndex(wrIdxA), .rf_writeData(wrDataA)
    );

    regfile_stream_port #(.width(32), .n(5), .size(20)) dutB (
        .clk(clk), .rst(rst),
        .cmd_valid(cmdValidB), .cmd_ready(cmdReadyB), .cmd_op(cmdOpB),
        .cmd_base(cmdBaseB), .cmd_count(cmdCountB),
        .in_valid(inValidB), .in_ready(inReadyB), .in_data(inDataB),
        .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB),
        .out_last(outLastB), .done(doneB),
        .rf_readReq(rdReqB), .rf_readResp(rdRespB),
        .rf_writeEn(wrEnB), .rf_writeIndex(wrIdxB), .rf_writeData(wrDataB)
    );

    assign rdRespA = memA[rdReqA];
    assign rdRespB = memB[rdReqB];

    always @(posedge clk) begin
        if (wrEnA) memA[wrIdxA] <= wrDataA;
        if (wrEnB) memB[wrIdxB] <= wrDataB;
    end

    initial begin
        bit         pat [7];
        bit         gaps [6];
        int         got;
        int         wr;
        bit         prevStall;
        bit         fin;
        logic [31:0] heldData;
        logic [4:0]  idxB [4];

        for (int i = 0; i < 32; i++) begin
            memA[i] = 32'hF00 + i;
            memB[i] = 32'hE00 + i;
        end

        // reset
        tick; tick;
        check("rst_cmd_ready", cmdReadyA, 0);
        check("rst_out_valid", outValidA, 0);
        check("rst_done", doneA, 0);
        rst = 0;
        #1;
        check("idle_cmd_ready", cmdReadyA, 1);
        tick;

        // LOAD base=3 count=4, in_valid held high
        cmdValidA = 1; cmdOpA = 0; cmdBaseA = 3; cmdCountA = 4;
        #1 check("ld_accept", cmdReadyA, 1);
        tick;
        cmdValidA = 0;
        for (int k = 0; k < 4; k++) begin
            inValidA = 1; inDataA = 32'hA0 + k;
            #1;
            check("ld_in_ready", inReadyA, 1);
            check("ld_we", wrEnA, 1);
            check("ld_idx", wrIdxA, 3 + k);
            check("ld_data", wrDataA, 32'hA0 + k);
            check("ld_no_done", doneA, 0);
            tick;
        end
        inValidA = 0;
        #1;
        check("ld_done", doneA, 1);
        check("ld_done_cmd_ready", cmdReadyA, 0);
        check("ld_done_in_ready", inReadyA, 0);
        tick;
        check("ld_post_done", doneA, 0);
        check("ld_post_cmd_ready", cmdReadyA, 1);
        for (int k = 0; k < 4; k++) check("ld_mem", memA[3 + k], 32'hA0 + k);
        check("ld_mem_untouched", memA[7], 32'hF07);

        // DUMP base=3 count=4, out_ready=1
        outReadyA = 1;
        cmdValidA = 1; cmdOpA = 1; cmdBaseA = 3; cmdCountA = 4;
        #1 check("dp_accept", cmdReadyA, 1);
        tick;
        cmdValidA = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("dp_valid", outValidA, 1);
            check("dp_data", outDataA, 32'hA0 + k);
            check("dp_last", outLastA, k == 3);
            check("dp_we", wrEnA, 0);
            tick;
        end
        #1;
        check("dp_done", doneA, 1);
        check("dp_valid_off", outValidA, 0);
        tick;

        // DUMP with stalls
        pat = '{1, 0, 0, 1, 0, 1, 1};
        cmdValidA = 1; cmdOpA = 1; cmdBaseA = 3; cmdCountA = 4;
        tick;
        cmdValidA = 0;
        got = 0; prevStall = 0; fin = 0; heldData = '0;
        for (int c = 0; c < 16 && !fin; c++) begin
            outReadyA = (c < 7) ? pat[c] : 1'b1;
            #1;
            if (doneA) fin = 1;
            else if (outValidA) begin
                if (prevStall) check("st_hold", outDataA, heldData);
                if (outReadyA) begin
                    check("st_data", outDataA, 32'hA0 + got);
                    check("st_last", outLastA, got == 3);
                    got++;
                    prevStall = 0;
                end else begin
                    prevStall = 1;
                    heldData  = outDataA;
                end
            end
            tick;
        end
        check("st_count", got, 4);
        check("st_done", fin, 1);
        outReadyA = 0;

        // LOAD count=3 with input gaps
        gaps = '{1, 0, 1, 0, 0, 1};
        cmdValidA = 1; cmdOpA = 0; cmdBaseA = 10; cmdCountA = 3;
        tick;
        cmdValidA = 0;
        wr = 0;
        for (int c = 0; c < 6; c++) begin
            inValidA = gaps[c];
            inDataA  = gaps[c] ? 32'hB0 + wr : 32'hDEAD;
            #1;
            check("gp_we", wrEnA, gaps[c]);
            if (gaps[c]) begin
                check("gp_idx", wrIdxA, 10 + wr);
                check("gp_data", wrDataA, 32'hB0 + wr);
                wr++;
            end
            check("gp_no_done", doneA, 0);
            tick;
        end
        inValidA = 0;
        #1 check("gp_done", doneA, 1);
        tick;
        for (int k = 0; k < 3; k++) check("gp_mem", memA[10 + k], 32'hB0 + k);
        check("gp_mem_untouched", memA[13], 32'hF0D);

        // count == 0
        cmdValidA = 1; cmdOpA = 0; cmdBaseA = 7; cmdCountA = 0;
        tick;
        cmdValidA = 0;
        inValidA = 1; inDataA = 32'h5555;
        #1;
        check("z_done", doneA, 1);
        check("z_we", wrEnA, 0);
        check("z_out_valid", outValidA, 0);
        tick;
        inValidA = 0;
        #1 check("z_cmd_ready", cmdReadyA, 1);
        check("z_mem", memA[7], 32'hF07);

        // size=20: LOAD base=18 count=4 wraps to 0
        idxB = '{18, 19, 0, 1};
        cmdValidB = 1; cmdOpB = 0; cmdBaseB = 18; cmdCountB = 4;
        tick;
        cmdValidB = 0;
        for (int k = 0; k < 4; k++) begin
            inValidB = 1; inDataB = 32'hD0 + k;
            #1;
            check("w_we", wrEnB, 1);
            check("w_idx", wrIdxB, idxB[k]);
            check("w_data", wrDataB, 32'hD0 + k);
            tick;
        end
        inValidB = 0;
        #1 check("w_done", doneB, 1);
        tick;
        check("w_mem0", memB[0], 32'hD2);
        check("w_mem20", memB[20], 32'hE14);

        // size=20: DUMP base=18 count=4
        outReadyB = 1;
        cmdValidB = 1; cmdOpB = 1; cmdBaseB = 18; cmdCountB = 4;
        tick;
        cmdValidB = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("wd_valid", outValidB, 1);
            check("wd_data", outDataB, 32'hD0 + k);
            check("wd_last", outLastB, k == 3);
            tick;
        end
        #1 check("wd_done", doneB, 1);
        tick;

        // reset in the middle of a LOAD
        cmdValidA = 1; cmdOpA = 0; cmdBaseA = 20; cmdCountA = 5;
        tick;
        cmdValidA = 0;
        for (int k = 0; k < 2; k++) begin
            inValidA = 1; inDataA = 32'hC0 + k;
            tick;
        end
        inDataA = 32'hC2;
        rst = 1;
        #1;
        check("ab_we", wrEnA, 0);
        check("ab_in_ready", inReadyA, 0);
        check("ab_cmd_ready", cmdReadyA, 0);
        tick;
        rst = 0; inValidA = 0;
        #1;
        check("ab_no_done", doneA, 0);
        check("ab_out_valid", outValidA, 0);
        tick;
        check("ab_cmd_ready_after", cmdReadyA, 1);
        check("ab_no_done2", doneA, 0);
        check("ab_mem20", memA[20], 32'hC0);
        check("ab_mem21", memA[21], 32'hC1);
        check("ab_mem22", memA[22], 32'hF16);
        check("ab_mem23", memA[23], 32'hF17);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
